// File: rtl/gpio_irq_arbiter.sv
// Round-robin interrupt arbiter for a GPIO bank: picks one eligible pending pin,
// presents its ID with a valid/ack handshake and pulses a one-hot clear on ack.
module gpio_irq_arbiter #(
  parameter int NUM_PINS = 32,
  parameter int IDW      = $clog2(NUM_PINS),
  parameter int MIN_GAP  = 2
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [NUM_PINS-1:0] irq_pending,
  input  logic [NUM_PINS-1:0] irq_mask,
  input  logic                irq_ack,
  output logic                irq_valid,
  output logic [IDW-1:0]      irq_id,
  output logic [NUM_PINS-1:0] irq_clear,
  output logic                busy
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_PINS - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PRESENT,
    GAP
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [GW-1:0]        gapCnt_q, gapCnt_d;
  logic [NUM_PINS-1:0]  clear_q, clear_d;
  logic [NUM_PINS-1:0]  eligSampled_q;
  logic                 valid_q;
  logic                 busy_q;

  logic [NUM_PINS-1:0]  elig;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       hiWin;
  logic [IDW-1:0]       loWin;
  logic                 hiFound;
  logic [IDW-1:0]       ptrAfterAck;

  assign elig = irq_pending & irq_mask;

  // Descending scan leaves the lowest set index at or above ptr (hiWin) and the
  // lowest set index overall (loWin), which is the wrapped-around choice.
  always_comb begin
    hiFound = 1'b0;
    hiWin   = '0;
    loWin   = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        loWin = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hiWin   = IDW'(i);
          hiFound = 1'b1;
        end
      end
    end
    winner = hiFound ? hiWin : loWin;
  end

  assign ptrAfterAck = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);

  // IDLE wakes on the registered eligibility so that, after GAP, a pin whose
  // clear is still in flight through the status register is not re-presented.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    gapCnt_d = gapCnt_q;
    clear_d  = '0;
    case (state_q)
      IDLE: begin
        if (|eligSampled_q) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (|elig) begin
          id_d    = winner;
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          clear_d  = NUM_PINS'(1) << id_q;
          ptr_d    = ptrAfterAck;
          gapCnt_d = '0;
          state_d  = (MIN_GAP == 0) ? IDLE : GAP;
        end else if (!elig[id_q]) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      gapCnt_q      <= '0;
      clear_q       <= '0;
      eligSampled_q <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      gapCnt_q      <= gapCnt_d;
      clear_q       <= clear_d;
      eligSampled_q <= elig;
      valid_q       <= (state_d == PRESENT);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign irq_clear = clear_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// Directed bench for gpio_irq_arbiter: reset, latency, wrap, withdrawal,
// ack-vs-withdrawal race and reset during a handshake.
module tb_gpio_irq_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] irq_pending;
  logic [31:0] irq_mask;
  logic        irq_ack;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic [31:0] irq_clear;
  logic        busy;

  int checks = 0;
  int errors = 0;

  gpio_irq_arbiter #(
    .NUM_PINS(32),
    .IDW(5),
    .MIN_GAP(2)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .irq_pending(irq_pending),
    .irq_mask(irq_mask),
    .irq_ack(irq_ack),
    .irq_valid(irq_valid),
    .irq_id(irq_id),
    .irq_clear(irq_clear),
    .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pending, input logic [31:0] mask,
                               input logic ack);
    irq_pending = pending;
    irq_mask    = mask;
    irq_ack     = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (irq_valid === 1'b1) break;
      tick();
    end
    checkOutput(tag, {31'd0, irq_valid}, 32'd1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (busy === 1'b0) break;
      tick();
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic doReset();
    PRESET = 1'b1;
    applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0);
    tick(2);
    PRESET = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] test 1: reset with everything pending");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t1_valid", {31'd0, irq_valid}, 32'd0);
      checkOutput("t1_clear", irq_clear, 32'd0);
      checkOutput("t1_busy", {31'd0, busy}, 32'd0);
    end
    doReset();

    $display("[TB] test 2: single pin latency, ack, gap");
    applyStimulus(32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
    tick();
    checkOutput("t2_valid_n", {31'd0, irq_valid}, 32'd0);
    tick();
    checkOutput("t2_valid_n1", {31'd0, irq_valid}, 32'd0);
    checkOutput("t2_busy_n1", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t2_valid_n2", {31'd0, irq_valid}, 32'd1);
    checkOutput("t2_id", {27'd0, irq_id}, 32'd4);
    irq_ack = 1'b1;
    tick();
    applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0);
    checkOutput("t2_clear", irq_clear, 32'h0000_0010);
    checkOutput("t2_valid_gap", {31'd0, irq_valid}, 32'd0);
    checkOutput("t2_busy_gap0", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t2_clear_once", irq_clear, 32'd0);
    checkOutput("t2_busy_gap1", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("t2_busy_idle", {31'd0, busy}, 32'd0);

    $display("[TB] test 3: round robin wrap 0 <-> 31");
    doReset();
    applyStimulus(32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    for (int r = 0; r < 4; r++) begin
      logic [4:0] expId;
      expId = (r % 2 == 0) ? 5'd0 : 5'd31;
      waitValid("t3_valid", 10);
      checkOutput("t3_id", {27'd0, irq_id}, {27'd0, expId});
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checkOutput("t3_clear", irq_clear, 32'd1 << expId);
    end

    $display("[TB] test 4: withdrawal by mask");
    doReset();
    applyStimulus(32'h0000_0100, 32'hFFFF_FFFF, 1'b0);
    waitValid("t4_valid", 10);
    checkOutput("t4_id", {27'd0, irq_id}, 32'd8);
    irq_mask = 32'hFFFF_FEFF;
    tick();
    checkOutput("t4_valid_drop", {31'd0, irq_valid}, 32'd0);
    checkOutput("t4_clear0", irq_clear, 32'd0);
    tick();
    checkOutput("t4_clear1", irq_clear, 32'd0);
    checkOutput("t4_busy", {31'd0, busy}, 32'd0);
    applyStimulus(32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    waitValid("t4_valid2", 10);
    checkOutput("t4_ptr_kept", {27'd0, irq_id}, 32'd0);

    $display("[TB] test 5: ack and withdrawal in the same cycle");
    doReset();
    applyStimulus(32'h0000_0008, 32'hFFFF_FFFF, 1'b0);
    waitValid("t5_valid", 10);
    checkOutput("t5_id", {27'd0, irq_id}, 32'd3);
    applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b1);
    tick();
    irq_ack = 1'b0;
    checkOutput("t5_clear", irq_clear, 32'h0000_0008);
    applyStimulus(32'h0000_002A, 32'hFFFF_FFFF, 1'b0);
    waitValid("t5_valid2", 12);
    checkOutput("t5_ptr_adv", {27'd0, irq_id}, 32'd5);

    $display("[TB] test 6: reset during handshake");
    doReset();
    applyStimulus(32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
    waitValid("t6_valid_a", 10);
    irq_ack = 1'b1;
    tick();
    applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b0);
    waitIdle("t6_idle", 10);
    irq_pending = 32'h0000_0144;
    waitValid("t6_valid_b", 10);
    checkOutput("t6_id_pre", {27'd0, irq_id}, 32'd6);
    PRESET  = 1'b1;
    irq_ack = 1'b1;
    tick();
    PRESET  = 1'b0;
    irq_ack = 1'b0;
    checkOutput("t6_clear", irq_clear, 32'd0);
    checkOutput("t6_valid", {31'd0, irq_valid}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("t6_clear_next", irq_clear, 32'd0);
    waitValid("t6_valid_c", 10);
    checkOutput("t6_ptr_zero", {27'd0, irq_id}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
